// File: rtl/packet_queue_bank_if.sv
// ---------------------------------------------------------------------------
// packet_queue_bank_if
//
// Bundles the host-side Avalon-MM slave signals and the scheduler dequeue
// port of packet_queue_bank into one interface.
//
// Signals:
//   chipselect, write, read  Avalon slave strobes (host -> bank)
//   address   [ADDR_W]       queue / drop-counter address
//   writedata [DATA_W]       enqueue data
//   readdata  [DATA_W]       registered read data (bank -> host)
//   deq_req                  scheduler dequeue request
//   deq_sel   [clog2(NUM_Q)] queue selected for dequeue
//   deq_valid                deq_data holds a dequeued entry
//   deq_data  [DATA_W]       dequeued entry
//   empty, full [NUM_Q]      per-queue status flags
//
// Modports:
//   master  host + scheduler side (drives requests, observes results)
//   slave   the queue bank itself
// ---------------------------------------------------------------------------
interface packet_queue_bank_if #(
    parameter int NUM_Q  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    localparam int SEL_W = $clog2(NUM_Q);

    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              deq_req;
    logic [SEL_W-1:0]  deq_sel;
    logic              deq_valid;
    logic [DATA_W-1:0] deq_data;
    logic [NUM_Q-1:0]  empty;
    logic [NUM_Q-1:0]  full;

    modport master (
        output chipselect, write, read, address, writedata, deq_req, deq_sel,
        input  readdata, deq_valid, deq_data, empty, full
    );

    modport slave (
        input  chipselect, write, read, address, writedata, deq_req, deq_sel,
        output readdata, deq_valid, deq_data, empty, full
    );
endinterface

// File: rtl/packet_queue_bank.sv
// ---------------------------------------------------------------------------
// packet_queue_bank
//
// Bank of NUM_Q independent circular FIFOs. The host enqueues bytes through
// an Avalon-MM slave and reads back per-queue occupancy and overflow drop
// counts; a scheduler pulls entries through one registered dequeue port.
//
// Ports:
//   clk     system clock
//   reset   synchronous, active-high reset
//   irq     (only with PQB_DROP_IRQ_EN) high while any drop counter != 0
//   bus     packet_queue_bank_if.slave (Avalon slave + dequeue + flags)
//
// Address map:
//   a <  NUM_Q          write: enqueue into queue a; read: occupancy
//   NUM_Q <= a < 2NUM_Q write: clear drop counter; read: drop counter
//   otherwise           reads return 0, writes ignored
//
// Optional feature macro: PQB_DROP_IRQ_EN
// ---------------------------------------------------------------------------
module packet_queue_bank #(
    parameter int NUM_Q  = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 3
) (
    input  logic clk,
    input  logic reset,
`ifdef PQB_DROP_IRQ_EN
    output logic irq,
`endif
    packet_queue_bank_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_QW = PTR_W + 1;
    localparam int SEL_W  = $clog2(NUM_Q);

    localparam logic [CNT_QW-1:0] CNT_FULL = CNT_QW'(DEPTH);
    localparam logic [CNT_W-1:0]  DROP_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] mem      [NUM_Q][DEPTH];
    logic [PTR_W-1:0]  wr_ptr   [NUM_Q];
    logic [PTR_W-1:0]  rd_ptr   [NUM_Q];
    logic [CNT_QW-1:0] count    [NUM_Q];
    logic [CNT_W-1:0]  drop_cnt [NUM_Q];

    logic [NUM_Q-1:0]  enq_req;
    logic [NUM_Q-1:0]  enq_ok;
    logic [NUM_Q-1:0]  deq_go;
    logic [NUM_Q-1:0]  drop;
    logic [NUM_Q-1:0]  clr;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] rd_value;

    // Per-queue request decode. A full queue still accepts an enqueue when
    // the same queue is dequeued this cycle, since the slot frees up at the
    // same edge. An empty queue never dequeues, so there is no bypass.
    always_comb begin
        enq_req   = '0;
        enq_ok    = '0;
        deq_go    = '0;
        drop      = '0;
        clr       = '0;
        head_data = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            enq_req[i] = bus.chipselect && bus.write && (bus.address == ADDR_W'(i));
            clr[i]     = bus.chipselect && bus.write && (bus.address == ADDR_W'(NUM_Q + i));
            deq_go[i]  = bus.deq_req && (bus.deq_sel == SEL_W'(i)) && (count[i] != '0);
            enq_ok[i]  = enq_req[i] && ((count[i] != CNT_FULL) || deq_go[i]);
            drop[i]    = enq_req[i] && !enq_ok[i];
            if (deq_go[i]) begin
                head_data = mem[i][rd_ptr[i]];
            end
        end
    end

    // Host read mux, sampled from the pre-update registered state.
    always_comb begin
        rd_value = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (bus.address == ADDR_W'(i)) begin
                rd_value = DATA_W'(count[i]);
            end
            if (bus.address == ADDR_W'(NUM_Q + i)) begin
                rd_value = DATA_W'(drop_cnt[i]);
            end
        end
    end

    // Pointers, occupancy and drop counters. Pointers wrap naturally because
    // DEPTH is a power of two. A host clear beats a same-cycle overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_Q; i++) begin
                wr_ptr[i]   <= '0;
                rd_ptr[i]   <= '0;
                count[i]    <= '0;
                drop_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_Q; i++) begin
                if (enq_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (deq_go[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                if (enq_ok[i] && !deq_go[i]) begin
                    count[i] <= count[i] + 1'b1;
                end else if (!enq_ok[i] && deq_go[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
                if (clr[i]) begin
                    drop_cnt[i] <= '0;
                end else if (drop[i] && (drop_cnt[i] != DROP_MAX)) begin
                    drop_cnt[i] <= drop_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Entry storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_Q; i++) begin
            if (enq_ok[i]) begin
                mem[i][wr_ptr[i]] <= bus.writedata;
            end
        end
    end

    // Registered dequeue and read-data outputs; both hold between events.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.deq_valid <= 1'b0;
            bus.deq_data  <= '0;
            bus.readdata  <= '0;
        end else begin
            bus.deq_valid <= |deq_go;
            if (|deq_go) begin
                bus.deq_data <= head_data;
            end
            if (bus.chipselect && bus.read) begin
                bus.readdata <= rd_value;
            end
        end
    end

    always_comb begin
        bus.empty = '0;
        bus.full  = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            bus.empty[i] = (count[i] == '0);
            bus.full[i]  = (count[i] == CNT_FULL);
        end
    end

`ifdef PQB_DROP_IRQ_EN
    logic any_drop;

    always_comb begin
        any_drop = 1'b0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (drop_cnt[i] != '0) begin
                any_drop = 1'b1;
            end
        end
    end

    // Follows the registered counters, so it drops one cycle after the last
    // non-zero counter is cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= any_drop;
        end
    end
`endif

endmodule
